// File: rtl/heu_pkg.sv
// Shared types and constants for the IPGU->HEU window receiver.
// Level geometry, window tag and row/buffer layouts.
package heu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int WIN_DIM    = 20;
  localparam int STRIDE     = 10;
  localparam int NUM_LEVELS = 6;
  localparam int BUF_ENT    = 5;
  localparam int ENT_BYTES  = 80;

  localparam logic [8:0] LEVEL_DIM [NUM_LEVELS] = '{
    9'd300, 9'd240, 9'd180, 9'd120, 9'd60, 9'd20
  };

  typedef logic [DATA_WIDTH-1:0] pix_t;
  typedef pix_t [WIN_DIM-1:0] pix_row_t;
  typedef pix_t [BUF_ENT-1:0][ENT_BYTES-1:0] win_buf_t;

  typedef struct packed {
    logic [2:0] level;
    logic [8:0] row;
    logic [8:0] col;
  } win_tag_t;

  localparam win_tag_t LAST_TAG = '{
    level: 3'(NUM_LEVELS-1),
    row:   9'd0,
    col:   9'd0
  };

  function automatic logic [8:0] level_dim(
    input logic [2:0] lvl
  );
    level_dim = LEVEL_DIM[0];
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (lvl == 3'(i)) level_dim = LEVEL_DIM[i];
    end
  endfunction

  // Four window rows are packed per 80-byte buffer entry.
  function automatic pix_row_t sel_row(
    input win_buf_t   b,
    input logic [4:0] idx
  );
    logic [2:0] ent;
    logic [6:0] base;
    ent  = idx[4:2];
    base = 7'(idx[1:0]) * 7'd20;
    for (int k = 0; k < WIN_DIM; k++) begin
      sel_row[k] = b[ent][base + 7'(k)];
    end
  endfunction

endpackage

// File: rtl/heu_win_rx_if.sv
// Window-in / row-out bundle of the HEU receiver.
// slave is the receiver view, master the surrounding logic.
interface heu_win_rx_if;
  import heu_pkg::*;

  logic       vldIpgu;
  win_buf_t   ipguOutBufferQ;
  logic       rdyHeu;

  logic       out_vld;
  logic       out_rdy;
  pix_row_t   out_row;
  logic [4:0] out_row_idx;
  logic       out_last;
  logic [2:0] win_level;
  logic [8:0] win_row;
  logic [8:0] win_col;

  modport slave (
    input  vldIpgu, ipguOutBufferQ, out_rdy,
    output rdyHeu, out_vld, out_row,
    output out_row_idx, out_last,
    output win_level, win_row, win_col
  );

  modport master (
    output vldIpgu, ipguOutBufferQ, out_rdy,
    input  rdyHeu, out_vld, out_row,
    input  out_row_idx, out_last,
    input  win_level, win_row, win_col
  );

endinterface

// File: rtl/win_origin_cnt.sv
// Pyramid level / window origin counter.
// Steps one stride per captured window, wrapping per level and frame.
module win_origin_cnt
  import heu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     adv_i,
  output win_tag_t tag_o
);

  logic [2:0] level_q, level_d;
  logic [8:0] row_q, row_d;
  logic [8:0] col_q, col_d;
  logic [9:0] dim;
  logic       col_end;
  logic       row_end;

  assign dim     = {1'b0, level_dim(level_q)};
  assign col_end = ({1'b0, col_q} + 10'(WIN_DIM)) >= dim;
  assign row_end = ({1'b0, row_q} + 10'(WIN_DIM)) >= dim;

  always_comb begin
    level_d = level_q;
    row_d   = row_q;
    col_d   = col_q;
    if (adv_i) begin
      if (!col_end) begin
        col_d = col_q + 9'(STRIDE);
      end else if (!row_end) begin
        col_d = '0;
        row_d = row_q + 9'(STRIDE);
      end else begin
        col_d = '0;
        row_d = '0;
        if (level_q == 3'(NUM_LEVELS-1)) begin
          level_d = '0;
        end else begin
          level_d = level_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      level_q <= level_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign tag_o = '{level: level_q, row: row_q, col: col_q};

endmodule

// File: rtl/heu_win_rx.sv
// IPGU->HEU window receiver: two-slot ping-pong window store
// that streams each tagged window one 20-pixel row per beat.
module heu_win_rx
  import heu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  heu_win_rx_if.slave  bus,
  output logic         frame_done
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'(WIN_DIM-1);

  state_e     state_q;
  win_buf_t   slot_q [2];
  win_tag_t   tag_q  [2];
  logic [1:0] full_q, full_d;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic       rdy_q;
  logic [4:0] idx_q;
  pix_row_t   row_q;
  logic       last_q;
  win_tag_t   otag_q;
  logic       fd_q;

  win_tag_t   cnt_tag;
  logic       cap;
  logic       rel;

  assign cap = bus.vldIpgu & rdy_q;
  assign rel = (state_q == STREAM) & bus.out_rdy
             & (idx_q == LAST_IDX);

  win_origin_cnt u_origin (
    .clk   (clk),
    .rst   (rst),
    .adv_i (cap),
    .tag_o (cnt_tag)
  );

  // Capture and release may hit opposite slots in one cycle.
  always_comb begin
    full_d = full_q;
    if (rel) full_d[rd_ptr_q] = 1'b0;
    if (cap) full_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      slot_q[wr_ptr_q] <= bus.ipguOutBufferQ;
      tag_q[wr_ptr_q]  <= cnt_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rdy_q    <= 1'b1;
      idx_q    <= '0;
      row_q    <= '0;
      last_q   <= 1'b0;
      otag_q   <= '0;
      fd_q     <= 1'b0;
    end else begin
      full_q <= full_d;
      rdy_q  <= ~&full_d;
      fd_q   <= rel && (otag_q == LAST_TAG);
      if (cap) wr_ptr_q <= ~wr_ptr_q;
      unique case (state_q)
        IDLE: begin
          if (full_q[rd_ptr_q]) begin
            state_q <= STREAM;
            idx_q   <= '0;
            last_q  <= 1'b0;
            row_q   <= sel_row(slot_q[rd_ptr_q], 5'd0);
            otag_q  <= tag_q[rd_ptr_q];
          end
        end
        STREAM: begin
          if (bus.out_rdy) begin
            if (idx_q != LAST_IDX) begin
              idx_q  <= idx_q + 5'd1;
              last_q <= (idx_q == LAST_IDX - 5'd1);
              row_q  <= sel_row(slot_q[rd_ptr_q],
                                idx_q + 5'd1);
            end else begin
              rd_ptr_q <= ~rd_ptr_q;
              idx_q    <= '0;
              last_q   <= 1'b0;
              // Chain straight into an already-full slot.
              if (full_q[~rd_ptr_q]) begin
                row_q  <= sel_row(slot_q[~rd_ptr_q], 5'd0);
                otag_q <= tag_q[~rd_ptr_q];
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.rdyHeu      = rdy_q;
  assign bus.out_vld     = (state_q == STREAM);
  assign bus.out_row     = row_q;
  assign bus.out_row_idx = idx_q;
  assign bus.out_last    = last_q;
  assign bus.win_level   = otag_q.level;
  assign bus.win_row     = otag_q.row;
  assign bus.win_col     = otag_q.col;
  assign frame_done      = fd_q;

endmodule

// File: tb/tb_heu_win_rx.sv
// Self-checking bench for heu_win_rx: directed sequences,
// a beat monitor and a table of window-tag vectors.
module tb_heu_win_rx;
  import heu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_done;

  heu_win_rx_if bus();

  heu_win_rx dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [2:0] lvl;
    logic [8:0] row;
    logic [8:0] col;
  } tvec_t;

  int checks = 0;
  int errors = 0;
  int sent = 0;
  int stop_at = 1 << 30;
  int beat = 0;
  int fd_cnt = 0;
  bit fd_exp = 1'b0;
  int expq[$];
  win_tag_t obs_tag [1807];
  bit obs_seen [1807];
  tvec_t tv [11];

  function automatic win_buf_t make_win(int id);
    win_buf_t b;
    b = '0;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 20; c++)
        b[r/4][(r%4)*20+c] = 8'((id*37 + r*20 + c) & 255);
    return b;
  endfunction

  function automatic pix_row_t exp_row(int id, int r);
    pix_row_t p;
    for (int c = 0; c < 20; c++)
      p[c] = 8'((id*37 + r*20 + c) & 255);
    return p;
  endfunction

  function automatic win_tag_t tag_of(int n);
    int dims [6] = '{300, 240, 180, 120, 60, 20};
    int k;
    win_tag_t t;
    t = '0;
    n = n % 1806;
    for (int l = 0; l < 6; l++) begin
      k = (dims[l] - 20) / 10 + 1;
      if (n < k*k) begin
        t.level = 3'(l);
        t.row = 9'((n / k) * 10);
        t.col = 9'((n % k) * 10);
        return t;
      end
      n -= k*k;
    end
    return t;
  endfunction

  task automatic chk(string name, logic [159:0] act,
                     logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.ipguOutBufferQ = make_win(sent);
    if (sent >= stop_at) bus.vldIpgu = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.vldIpgu = 1'b0;
    bus.out_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idx(int target, string name);
    int i;
    for (i = 0; i < 100; i++) begin
      if (bus.out_vld && bus.out_row_idx == 5'(target)) break;
      tick();
    end
    chk(name, 160'(i < 100), 160'd1);
  endtask

  task automatic wait_idle(string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (!bus.out_vld) break;
      tick();
    end
    chk(name, 160'(i < 200), 160'd1);
  endtask

  // Beat monitor: samples at negedge what the next edge will transfer.
  always @(negedge clk) begin : mon
    win_tag_t t;
    int id;
    if (rst) begin
      expq.delete();
      sent = 0;
      beat = 0;
      fd_exp = 1'b0;
    end else begin
      if (frame_done || fd_exp)
        chk("frame_done", 160'(frame_done), 160'(fd_exp));
      if (frame_done) fd_cnt++;
      fd_exp = 1'b0;
      if (bus.vldIpgu && bus.rdyHeu) begin
        expq.push_back(sent);
        sent++;
      end
      if (bus.out_vld && bus.out_rdy) begin
        if (expq.size() == 0) begin
          chk("spurious_beat", 160'd1, 160'd0);
        end else begin
          id = expq[0];
          t = {bus.win_level, bus.win_row, bus.win_col};
          chk("beat_row", bus.out_row, exp_row(id, beat));
          chk("beat_idx", 160'(bus.out_row_idx), 160'(beat));
          chk("beat_last", 160'(bus.out_last), 160'(beat == 19));
          chk("beat_tag", 160'(t), 160'(tag_of(id)));
          if (beat == 0 && id < 1807) begin
            obs_tag[id] = t;
            obs_seen[id] = 1'b1;
          end
          if (beat == 19) begin
            fd_exp = (tag_of(id).level == 3'd5);
            void'(expq.pop_front());
            beat = 0;
          end else begin
            beat++;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int c;
    pix_row_t r0;
    win_tag_t want;

    tv[0]  = '{0,    3'd0, 9'd0,   9'd0};
    tv[1]  = '{28,   3'd0, 9'd0,   9'd280};
    tv[2]  = '{29,   3'd0, 9'd10,  9'd0};
    tv[3]  = '{840,  3'd0, 9'd280, 9'd280};
    tv[4]  = '{841,  3'd1, 9'd0,   9'd0};
    tv[5]  = '{1369, 3'd1, 9'd220, 9'd220};
    tv[6]  = '{1370, 3'd2, 9'd0,   9'd0};
    tv[7]  = '{1659, 3'd3, 9'd0,   9'd0};
    tv[8]  = '{1780, 3'd4, 9'd0,   9'd0};
    tv[9]  = '{1805, 3'd5, 9'd0,   9'd0};
    tv[10] = '{1806, 3'd0, 9'd0,   9'd0};

    bus.vldIpgu = 1'b0;
    bus.out_rdy = 1'b0;
    bus.ipguOutBufferQ = make_win(0);
    do_reset();

    chk("rst_rdy", 160'(bus.rdyHeu), 160'd1);
    chk("rst_vld", 160'(bus.out_vld), 160'd0);
    chk("rst_row", bus.out_row, 160'd0);
    chk("rst_idx", 160'(bus.out_row_idx), 160'd0);
    chk("rst_last", 160'(bus.out_last), 160'd0);
    chk("rst_tag", 160'({bus.win_level, bus.win_row,
                         bus.win_col}), 160'd0);
    chk("rst_fd", 160'(frame_done), 160'd0);

    // Single window, one-cycle capture-to-valid latency.
    bus.out_rdy = 1'b1;
    bus.vldIpgu = 1'b1;
    stop_at = 1;
    tick();
    chk("t1_vld_lat", 160'(bus.out_vld), 160'd0);
    chk("t1_rdy", 160'(bus.rdyHeu), 160'd1);
    tick();
    chk("t1_tag", 160'({bus.win_level, bus.win_row,
                        bus.win_col}), 160'd0);
    for (int b = 0; b < 20; b++) begin
      chk("t1_stream", 160'({bus.out_vld, bus.out_row_idx}),
          160'({1'b1, 5'(b)}));
      chk("t1_rdy_on", 160'(bus.rdyHeu), 160'd1);
      if (b == 7) chk("t1_pix143", 160'(bus.out_row[3]), 160'd143);
      tick();
    end
    chk("t1_done", 160'(bus.out_vld), 160'd0);

    // Three windows offered while the sink is stalled.
    base = sent;
    bus.out_rdy = 1'b0;
    bus.vldIpgu = 1'b1;
    stop_at = base + 3;
    tick();
    tick();
    chk("t2_rdy_full", 160'(bus.rdyHeu), 160'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold", 160'({bus.rdyHeu, bus.out_vld,
                           bus.out_row_idx}), 160'({2'b01, 5'd0}));
      tick();
    end
    chk("t2_two_cap", 160'(sent), 160'(base + 2));
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      chk("t2_nobubble", 160'({bus.out_vld, bus.out_row_idx}),
          160'({1'b1, 5'(i % 20)}));
      tick();
    end
    chk("t2_sent", 160'(sent), 160'(base + 3));
    chk("t2_idle", 160'(bus.out_vld), 160'd0);

    // Stall at row 12 with new windows still offered.
    base = sent;
    stop_at = 1 << 30;
    bus.vldIpgu = 1'b1;
    wait_idx(12, "t6_reach12");
    bus.out_rdy = 1'b0;
    r0 = bus.out_row;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_row_hold", bus.out_row, r0);
      chk("t6_idx_hold", 160'(bus.out_row_idx), 160'd12);
      chk("t6_rdy_low", 160'(bus.rdyHeu), 160'd0);
    end
    chk("t6_cap_limit", 160'(sent), 160'(base + 2));
    bus.vldIpgu = 1'b0;
    bus.out_rdy = 1'b1;
    wait_idle("t6_drain");
    chk("t6_empty", 160'(expq.size()), 160'd0);

    // Reset at row 9 with the second slot full.
    base = sent;
    stop_at = base + 2;
    bus.vldIpgu = 1'b1;
    wait_idx(9, "t5_reach9");
    chk("t5_both_cap", 160'(sent), 160'(base + 2));
    stop_at = 1 << 30;
    rst = 1'b1;
    bus.vldIpgu = 1'b1;
    tick();
    chk("t5_rst_vld", 160'(bus.out_vld), 160'd0);
    chk("t5_rst_rdy", 160'(bus.rdyHeu), 160'd1);
    chk("t5_rst_idx", 160'(bus.out_row_idx), 160'd0);
    rst = 1'b0;
    bus.vldIpgu = 1'b0;
    tick();
    tick();
    chk("t5_no_inflight", 160'(bus.out_vld), 160'd0);
    stop_at = 1;
    bus.vldIpgu = 1'b1;
    tick();
    tick();
    chk("t5_restart", 160'({bus.out_vld, bus.out_row_idx}),
        160'({1'b1, 5'd0}));
    chk("t5_tag0", 160'({bus.win_level, bus.win_row,
                         bus.win_col}), 160'd0);
    wait_idle("t5_drain");
    chk("t5_one_win", 160'(sent), 160'd1);

    // Full frame plus one window under random backpressure.
    do_reset();
    for (int i = 0; i < 1807; i++) obs_seen[i] = 1'b0;
    fd_cnt = 0;
    stop_at = 1807;
    bus.vldIpgu = 1'b1;
    for (c = 0; c < 60000; c++) begin
      if (sent >= 1807 && expq.size() == 0 && !bus.out_vld) break;
      bus.out_rdy = ($urandom_range(0, 7) != 0);
      tick();
    end
    chk("frame_timeout", 160'(c < 60000), 160'd1);
    chk("frame_done_cnt", 160'(fd_cnt), 160'd1);
    for (int i = 0; i < 11; i++) begin
      want = '{level: tv[i].lvl, row: tv[i].row, col: tv[i].col};
      chk($sformatf("tag_vec_%0d", tv[i].id),
          160'({obs_seen[tv[i].id], obs_tag[tv[i].id]}),
          160'({1'b1, want}));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
